// File: rtl/conv_dw_seq.sv
// Depthwise 3x3 convolution sequencer: one MAC per tap per cycle across all channels,
// followed by floor shift, saturation and optional ReLU/ReLU6.
module conv_dw_seq #(
    parameter int CH   = 16,
    parameter int K    = 9,
    parameter int DW   = 16,
    parameter int FRAC = 15,
    parameter int ACT  = 2,
    parameter int CLIP = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CH*K*DW-1:0]      in_act,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH*DW-1:0]        out_act,
    input  logic                    cfg_we,
    input  logic [$clog2(CH)-1:0]   cfg_ch,
    input  logic [$clog2(K+1)-1:0]  cfg_tap,
    input  logic [DW-1:0]           cfg_data,
    output logic                    cfg_ready
);
    localparam int AW = 2*DW + $clog2(K) + 1;
    localparam int CW = $clog2(CH);
    localparam int TW = $clog2(K+1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic [1:0]              state_q, state_d;
    logic [TW-1:0]           tap_q, tap_d;
    logic signed [DW-1:0]    x_q [CH][K];
    logic signed [DW-1:0]    x_d [CH][K];
    logic signed [DW-1:0]    w_q [CH][K];
    logic signed [DW-1:0]    w_d [CH][K];
    logic signed [DW-1:0]    b_q [CH];
    logic signed [DW-1:0]    b_d [CH];
    logic signed [AW-1:0]    acc_q [CH];
    logic signed [AW-1:0]    acc_d [CH];
    logic signed [AW-1:0]    acc_nx [CH];
    logic [CH*DW-1:0]        out_q, out_d;
    logic [CH*DW-1:0]        res;
    // A write that coincides with an accept is held back until that vector finishes.
    logic                    pend_q, pend_d;
    logic [CW-1:0]           pch_q, pch_d;
    logic [TW-1:0]           ptap_q, ptap_d;
    logic [DW-1:0]           pdata_q, pdata_d;

    logic accept;
    logic cfg_ok;

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign cfg_ready = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_act   = out_q;
    assign accept    = in_valid && in_ready;
    assign cfg_ok    = cfg_we && cfg_ready && (int'(cfg_ch) < CH) && (int'(cfg_tap) <= K);

    always_comb begin
        logic signed [2*DW-1:0] prod;
        logic signed [AW-1:0]   sh;
        logic signed [DW-1:0]   v;
        for (int c = 0; c < CH; c++) begin
            prod      = w_q[c][tap_q] * x_q[c][tap_q];
            acc_nx[c] = acc_q[c] + AW'(prod);
            sh        = acc_nx[c] >>> FRAC;
            if (sh > MAXV)      v = MAXV[DW-1:0];
            else if (sh < MINV) v = MINV[DW-1:0];
            else                v = sh[DW-1:0];
            if (ACT == 1) begin
                if (v < 0) v = '0;
            end else if (ACT == 2) begin
                if (v < 0)                 v = '0;
                else if (int'(v) > CLIP)   v = DW'(CLIP);
            end
            res[c*DW +: DW] = v;
        end
    end

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        x_d     = x_q;
        w_d     = w_q;
        b_d     = b_q;
        acc_d   = acc_q;
        out_d   = out_q;
        pend_d  = pend_q;
        pch_d   = pch_q;
        ptap_d  = ptap_q;
        pdata_d = pdata_q;

        if (cfg_ok) begin
            if (accept) begin
                pend_d  = 1'b1;
                pch_d   = cfg_ch;
                ptap_d  = cfg_tap;
                pdata_d = cfg_data;
            end else if (int'(cfg_tap) == K) begin
                b_d[cfg_ch] = cfg_data;
            end else begin
                w_d[cfg_ch][cfg_tap] = cfg_data;
            end
        end

        case (state_q)
            S_MAC: begin
                acc_d = acc_nx;
                tap_d = tap_q + 1'b1;
                if (int'(tap_q) == K-1) begin
                    out_d   = res;
                    state_d = S_DONE;
                    if (pend_q) begin
                        pend_d = 1'b0;
                        if (int'(ptap_q) == K) b_d[pch_q] = pdata_q;
                        else                   w_d[pch_q][ptap_q] = pdata_q;
                    end
                end
            end
            S_DONE: begin
                if (out_ready && !in_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            for (int c = 0; c < CH; c++) begin
                for (int t = 0; t < K; t++) x_d[c][t] = in_act[(c*K+t)*DW +: DW];
                acc_d[c] = AW'(b_q[c]);
            end
            tap_d   = '0;
            state_d = S_MAC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tap_q   <= '0;
            out_q   <= '0;
            pend_q  <= 1'b0;
            pch_q   <= '0;
            ptap_q  <= '0;
            pdata_q <= '0;
            for (int c = 0; c < CH; c++) begin
                acc_q[c] <= '0;
                b_q[c]   <= '0;
                for (int t = 0; t < K; t++) begin
                    w_q[c][t] <= '0;
                    x_q[c][t] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            out_q   <= out_d;
            pend_q  <= pend_d;
            pch_q   <= pch_d;
            ptap_q  <= ptap_d;
            pdata_q <= pdata_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            w_q     <= w_d;
            x_q     <= x_d;
        end
    end
endmodule

// File: tb/tb_conv_dw_seq.sv
// Directed bench for conv_dw_seq: three instances (ACT none/ReLU/ReLU6) share one stimulus.
module tb_conv_dw_seq;
    localparam int CH = 2;
    localparam int K  = 9;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst, in_valid, out_ready, cfg_we;
    logic [CH*K*DW-1:0]    in_act;
    logic [0:0]            cfg_ch;
    logic [3:0]            cfg_tap;
    logic [DW-1:0]         cfg_data;
    logic                  ir0, ir1, ir2, ov0, ov1, ov2, cr0, cr1, cr2;
    logic [CH*DW-1:0]      o0, o1, o2;

    int n_chk = 0;
    int n_err = 0;

    conv_dw_seq #(.CH(CH), .K(K), .DW(DW), .FRAC(15), .ACT(0), .CLIP(6)) u_a0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_act(in_act),
        .out_valid(ov0), .out_ready(out_ready), .out_act(o0), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_tap(cfg_tap), .cfg_data(cfg_data), .cfg_ready(cr0));
    conv_dw_seq #(.CH(CH), .K(K), .DW(DW), .FRAC(15), .ACT(1), .CLIP(6)) u_a1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_act(in_act),
        .out_valid(ov1), .out_ready(out_ready), .out_act(o1), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_tap(cfg_tap), .cfg_data(cfg_data), .cfg_ready(cr1));
    conv_dw_seq #(.CH(CH), .K(K), .DW(DW), .FRAC(15), .ACT(2), .CLIP(6)) u_a2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_act(in_act),
        .out_valid(ov2), .out_ready(out_ready), .out_act(o2), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_tap(cfg_tap), .cfg_data(cfg_data), .cfg_ready(cr2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cfg_wr(input int ch, input int tap, input int data);
        cfg_we   = 1'b1;
        cfg_ch   = 1'(ch);
        cfg_tap  = 4'(tap);
        cfg_data = 16'(data);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic set_x(input int c, input int t, input int v);
        in_act[(c*K+t)*DW +: DW] = 16'(v);
    endtask

    // Counts negedges from the current one until out_valid, bounded.
    task automatic wait_out(output int lat);
        lat = 0;
        while (ov0 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2);
        int lat;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        chk({tag, "_lat"}, lat, 9);
        chk({tag, "_a0"}, o0, e0);
        chk({tag, "_a1"}, o1, e1);
        chk({tag, "_a2"}, o2, e2);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cfg_we = 1'b0;
        in_act = '0; cfg_ch = '0; cfg_tap = '0; cfg_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", ir0, 1);
        chk("rst_cfg_ready", cr0, 1);
        chk("rst_out_valid", ov0, 0);
        chk("rst_out_act", o0, 0);
        @(negedge clk);

        // 2 * 16384 = 32768 -> >>>15 = 1
        cfg_wr(0, 4, 16384);
        in_act = '0; set_x(0, 4, 2);
        run("basic", 32'h0000_0001, 32'h0000_0001, 32'h0000_0001);

        // bias -1 floors to -1
        cfg_wr(0, 9, -1);
        in_act = '0;
        run("floor", 32'h0000_FFFF, 32'h0, 32'h0);

        // -1 + 4*16384 = 65535 -> 1; a leaked w0=100 would add ~50
        in_act = '0; set_x(0, 4, 4); set_x(0, 0, 16384);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we = 1'b1; cfg_ch = 1'b0; cfg_tap = 4'd0; cfg_data = 16'd100;
        #1;
        chk("lock_cfg_ready", cr0, 0);
        @(negedge clk);
        cfg_we = 1'b0;
        wait_out(lat);
        chk("lock_lat", lat, 8);
        chk("lock_a0", o0, 32'h0000_0001);
        @(negedge clk);
        run("lock_again", 32'h0000_0001, 32'h0000_0001, 32'h0000_0001);

        // write w4=0 together with an accept: this vector still sees 16384
        cfg_we = 1'b1; cfg_ch = 1'b0; cfg_tap = 4'd4; cfg_data = 16'd0;
        in_valid = 1'b1;
        #1;
        chk("coin_in_ready", ir0, 1);
        @(negedge clk);
        cfg_we = 1'b0; in_valid = 1'b0;
        wait_out(lat);
        chk("coin_lat", lat, 9);
        chk("coin_old_a0", o0, 32'h0000_0001);
        @(negedge clk);
        run("coin_new", 32'h0000_FFFF, 32'h0, 32'h0);

        for (int c = 0; c < CH; c++)
            for (int t = 0; t < K; t++) cfg_wr(c, t, 32767);
        cfg_wr(0, 9, 0);
        for (int c = 0; c < CH; c++)
            for (int t = 0; t < K; t++) set_x(c, t, 32767);
        run("sat", 32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'h0006_0006);

        out_ready = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        chk("bp_lat", lat, 9);
        for (int i = 0; i < 5; i++) begin
            chk("bp_data", o0, 32'h7FFF_7FFF);
            chk("bp_in_ready", ir0, 0);
            chk("bp_valid", ov0, 1);
            @(negedge clk);
        end
        in_act = '0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("bb_in_ready", ir0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bb_gap", ov0, 0);
        wait_out(lat);
        chk("bb_period", lat + 1, 10);
        chk("bb_a0", o0, 32'h0);
        chk("bb_a2", o2, 32'h0);
        @(negedge clk);

        for (int c = 0; c < CH; c++)
            for (int t = 0; t < K; t++) set_x(c, t, 32767);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_in_ready", ir0, 1);
        chk("mrst_cfg_ready", cr0, 1);
        chk("mrst_valid", ov0, 0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (ov0) seen++;
        end
        chk("mrst_no_valid", seen, 0);
        run("post_rst", 32'h0, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/conv_dw_seq.md
CONV_DW_SEQ -- requirements
Module: conv_dw_seq

Interface
REQ-001 SHALL have parameter CH, default 16, meaning channel count.
REQ-002 SHALL have parameter K, default 9, meaning taps per channel (3x3 kernel).
REQ-003 SHALL have parameter DW, default 16, meaning signed activation/weight/bias width.
REQ-004 SHALL have parameter FRAC, default 15, meaning arithmetic right shift applied to the accumulator.
REQ-005 SHALL have parameter ACT, default 2, meaning activation: 0 none, 1 ReLU, 2 ReLU6.
REQ-006 SHALL have parameter CLIP, default 6, meaning the ReLU6 upper bound in output LSBs.
REQ-007 SHALL have port clk, input, 1 bit, the single clock.
REQ-008 SHALL have port rst, input, 1 bit, reset; it is synchronous and active-high.
REQ-009 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the input handshake.
REQ-010 SHALL have port in_act, input, CH*K*DW bits; channel c, tap t sits at bits [(c*K+t)*DW +: DW].
REQ-011 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the output handshake.
REQ-012 SHALL have port out_act, output, CH*DW bits; channel c sits at bits [c*DW +: DW].
REQ-013 SHALL have ports cfg_we (input, 1), cfg_ch (input, clog2(CH)), cfg_tap (input, clog2(K+1)), cfg_data (input, DW) and cfg_ready (output, 1); cfg_tap==K selects the bias.

Function
REQ-014 SHALL implement FSM states IDLE, MAC and DONE.
REQ-015 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready).
REQ-016 SHALL, on in_valid&&in_ready, latch in_act, preload each channel accumulator with its sign-extended bias, set tap=0 and enter MAC.
REQ-017 SHALL, in MAC, add w[c][tap]*x[c][tap] (signed DW x DW) to each accumulator once per cycle, all channels in parallel, and increment tap.
REQ-018 SHALL use an accumulator width of 2*DW+clog2(K)+1 bits, with no internal overflow.
REQ-019 SHALL, on the tap==K-1 cycle, register out_act = act(sat(acc_next >>> FRAC)) and enter DONE.
REQ-020 SHALL implement the shift as arithmetic with floor truncation (no rounding).
REQ-021 SHALL implement sat() as clamping to the signed DW range.
REQ-022 SHALL implement act(): ReLU maps negatives to 0; ReLU6 clamps to [0, CLIP]; mode none passes the value unchanged.
REQ-023 SHALL make latency K cycles: accept edge to the first cycle with out_valid=1.
REQ-024 SHALL assert out_valid only in DONE, holding out_act stable until out_ready.
REQ-025 SHALL, in DONE with out_ready, go to MAC if in_valid (back-to-back, one vector per K+1 cycles), else to IDLE.
REQ-026 SHALL ignore in_valid in MAC; in_act need not stay stable after acceptance.
REQ-027 SHALL drive cfg_ready = (state==IDLE).
REQ-028 SHALL write cfg_data into w[cfg_ch][cfg_tap] (or into the bias when cfg_tap==K) when cfg_we&&cfg_ready, visible to the next accepted vector.
REQ-029 SHALL drop cfg_we when cfg_ready=0 or when cfg_ch>=CH, with no state change.
REQ-030 SHALL give the accept path priority when cfg_we and in_valid coincide in IDLE: both take effect, and the accepted vector uses the weights as they were before the write.

Reset
REQ-031 SHALL, when rst=1 at a clock edge, force state=IDLE, tap=0, out_valid=0, out_act=0, all accumulators=0, all weights=0 and all biases=0.
REQ-032 SHALL, on reset mid-MAC or in DONE, abandon the pending result, with no out_valid afterwards.
REQ-033 SHALL drive in_ready=1 and cfg_ready=1 in the first cycle after rst deasserts.

Verification
REQ-034 SHALL cover basic MAC: CH=2, ACT=0, ch0 w[4]=16384, all other weights 0, bias 0, x[4]=2 -> out ch0=1, ch1=0, out_valid exactly 9 cycles after accept.
REQ-035 SHALL cover floor and ReLU: ch0 bias=-1, all inputs 0 -> ACT=0 gives -1 (0xFFFF); ACT=1 gives 0.
REQ-036 SHALL cover saturation and ReLU6: all weights 32767, all inputs 32767, bias 0, ACT=2 -> every channel outputs 6; ACT=0 -> 32767.
REQ-037 SHALL cover backpressure and back-to-back: hold out_ready=0 for 5 cycles -> out_act stable and in_ready=0; then out_ready=1 with in_valid=1 -> next vector accepted in the same cycle, next out_valid 10 cycles after the first.
REQ-038 SHALL cover config lockout: cfg_we during MAC with w=100 -> weight unchanged; the next result matches the old weights.
REQ-039 SHALL cover reset mid-MAC: rst at tap 4 -> out_valid stays 0, all weights read back as 0 (result 0 for any input), in_ready=1 next cycle.
